// File: rtl/srec_loader.sv
// srec_loader: Motorola S-record parser feeding a byte-wide memory load port.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   char_in[7:0]      ASCII character from the host/UART
//   char_valid        char_in valid this cycle
//   char_ready        loader accepts char_in (low only in DONE)
//   srec_address      byte address of the current write (registered)
//   srec_data_in      byte being written (registered)
//   srec_access_size  constant 2'b00, byte access
//   srec_rw           one-cycle write strobe
//   srec_parse        high while loading; processor stays stalled
//   done              sticky, termination record received
//   entry_pc          address field of the S7/S8/S9 record
//   err               sticky, format or checksum error seen
//   rec_count         records closed with a good checksum (saturating)
//   csum_err_count    records closed with a bad checksum (saturating)
module srec_loader #(
  parameter bit CSUM_CHECK = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  output logic [31:0]      srec_address,
  output logic [7:0]       srec_data_in,
  output logic [1:0]       srec_access_size,
  output logic             srec_rw,
  output logic             srec_parse,
  output logic             done,
  output logic [31:0]      entry_pc,
  output logic             err,
  output logic [CNT_W-1:0] rec_count,
  output logic [CNT_W-1:0] csum_err_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_TYPE, S_CNT_H, S_CNT_L, S_ADDR,
    S_DATA, S_CSUM, S_EOL, S_SKIP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       rtype_q, rtype_d;     // record type digit
  logic [2:0]       abytes_q, abytes_d;   // address field width in bytes
  logic [3:0]       hi_q, hi_d;           // pending high nibble
  logic [3:0]       nib_left_q, nib_left_d;
  logic             lo_phase_q, lo_phase_d;
  logic [31:0]      addr_q, addr_d;       // address field, then running write address
  logic [7:0]       dleft_q, dleft_d;     // data bytes still to come
  logic [7:0]       sum_q, sum_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             rw_q, rw_d;
  logic             parse_q, parse_d;
  logic             done_q, done_d;
  logic [31:0]      entry_q, entry_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] rec_q, rec_d;
  logic [CNT_W-1:0] cerr_q, cerr_d;

  logic       is_hex;
  logic [3:0] hex_val;
  logic [7:0] byte_val;
  logic [7:0] csum_total;
  logic       accept;
  logic       writable;
  logic       terminator;

  // ASCII hex digit decode; letters map via low nibble + 9 (A=0x41 -> 10).
  always_comb begin
    is_hex  = 1'b1;
    hex_val = 4'd0;
    if (char_in >= 8'h30 && char_in <= 8'h39) begin
      hex_val = char_in[3:0];
    end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                 (char_in >= 8'h61 && char_in <= 8'h66)) begin
      hex_val = char_in[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  assign byte_val   = {hi_q, hex_val};
  assign csum_total = sum_q + byte_val;
  assign accept     = char_valid && (state_q != S_DONE);
  assign writable   = (rtype_q == 4'd1) || (rtype_q == 4'd2) || (rtype_q == 4'd3);
  assign terminator = (rtype_q == 4'd7) || (rtype_q == 4'd8) || (rtype_q == 4'd9);

  always_comb begin
    state_d    = state_q;
    rtype_d    = rtype_q;
    abytes_d   = abytes_q;
    hi_d       = hi_q;
    nib_left_d = nib_left_q;
    lo_phase_d = lo_phase_q;
    addr_d     = addr_q;
    dleft_d    = dleft_q;
    sum_d      = sum_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rw_d       = 1'b0;
    parse_d    = parse_q;
    done_d     = done_q;
    entry_d    = entry_q;
    err_d      = err_q;
    rec_d      = rec_q;
    cerr_d     = cerr_q;

    // CR is transparent in every state.
    if (accept && char_in != 8'h0D) begin
      case (state_q)
        S_IDLE: if (char_in == 8'h53) state_d = S_TYPE;
        S_TYPE: begin
          if (char_in >= 8'h30 && char_in <= 8'h39 && char_in != 8'h34) begin
            rtype_d = char_in[3:0];
            case (char_in[3:0])
              4'd2, 4'd6, 4'd8: abytes_d = 3'd3;
              4'd3, 4'd7:       abytes_d = 3'd4;
              default:          abytes_d = 3'd2;
            endcase
            state_d = S_CNT_H;
          end else begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_CNT_H: begin
          if (is_hex) begin
            hi_d    = hex_val;
            state_d = S_CNT_L;
          end else begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_CNT_L: begin
          if (!is_hex || byte_val < ({5'd0, abytes_q} + 8'd1)) begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end else begin
            sum_d      = byte_val;
            dleft_d    = byte_val - {5'd0, abytes_q} - 8'd1;
            nib_left_d = {abytes_q, 1'b0};
            addr_d     = 32'd0;
            lo_phase_d = 1'b0;
            state_d    = S_ADDR;
          end
        end
        S_ADDR: begin
          if (is_hex) begin
            addr_d     = {addr_q[27:0], hex_val};
            nib_left_d = nib_left_q - 4'd1;
            // An even count of remaining nibbles means this is a high nibble.
            if (!nib_left_q[0]) hi_d = hex_val;
            else                sum_d = sum_q + byte_val;
            if (nib_left_q == 4'd1) state_d = (dleft_q == 8'd0) ? S_CSUM : S_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_DATA: begin
          if (!is_hex) begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end else if (!lo_phase_q) begin
            hi_d       = hex_val;
            lo_phase_d = 1'b1;
          end else begin
            lo_phase_d = 1'b0;
            sum_d      = sum_q + byte_val;
            dleft_d    = dleft_q - 8'd1;
            // Bytes are streamed out immediately; only load records write.
            if (writable) begin
              rw_d      = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = byte_val;
              addr_d    = addr_q + 32'd1;
            end
            if (dleft_q == 8'd1) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (!is_hex) begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end else if (!lo_phase_q) begin
            hi_d       = hex_val;
            lo_phase_d = 1'b1;
          end else begin
            lo_phase_d = 1'b0;
            if (csum_total == 8'hFF) begin
              if (rec_q != '1) rec_d = rec_q + CNT_W'(1);
            end else begin
              if (cerr_q != '1) cerr_d = cerr_q + CNT_W'(1);
              if (CSUM_CHECK) err_d = 1'b1;
            end
            state_d = S_EOL;
          end
        end
        S_EOL: begin
          if (char_in == 8'h0A) begin
            if (terminator) begin
              entry_d = addr_q;
              done_d  = 1'b1;
              parse_d = 1'b0;
              state_d = S_DONE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_SKIP: if (char_in == 8'h0A) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rtype_q    <= 4'd0;
      abytes_q   <= 3'd0;
      hi_q       <= 4'd0;
      nib_left_q <= 4'd0;
      lo_phase_q <= 1'b0;
      addr_q     <= 32'd0;
      dleft_q    <= 8'd0;
      sum_q      <= 8'd0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 8'd0;
      rw_q       <= 1'b0;
      parse_q    <= 1'b1;
      done_q     <= 1'b0;
      entry_q    <= 32'd0;
      err_q      <= 1'b0;
      rec_q      <= '0;
      cerr_q     <= '0;
    end else begin
      state_q    <= state_d;
      rtype_q    <= rtype_d;
      abytes_q   <= abytes_d;
      hi_q       <= hi_d;
      nib_left_q <= nib_left_d;
      lo_phase_q <= lo_phase_d;
      addr_q     <= addr_d;
      dleft_q    <= dleft_d;
      sum_q      <= sum_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rw_q       <= rw_d;
      parse_q    <= parse_d;
      done_q     <= done_d;
      entry_q    <= entry_d;
      err_q      <= err_d;
      rec_q      <= rec_d;
      cerr_q     <= cerr_d;
    end
  end

  assign char_ready       = (state_q != S_DONE);
  assign srec_address     = wr_addr_q;
  assign srec_data_in     = wr_data_q;
  assign srec_access_size = 2'b00;
  assign srec_rw          = rw_q;
  assign srec_parse       = parse_q;
  assign done             = done_q;
  assign entry_pc         = entry_q;
  assign err              = err_q;
  assign rec_count        = rec_q;
  assign csum_err_count   = cerr_q;

endmodule
